trng_health_stream: RTL and testbench

- Streaming online health monitor for raw TRNG words, placed between the TRNG core and the first FIFO.
- Runs a repetition-count test (RCT) and an adaptive-proportion bit-balance test (APT) on every accepted word.
- Forwards only passing words downstream over a valid/ready handshake.
- On failure it latches a sticky alarm, which the CPU or a status LED can observe. From that point no further data is emitted until the alarm is cleared.

---
 rtl/trng_health_pkg.sv | 16 +
 rtl/trng_health_stream_popcount.sv | 18 +
 rtl/trng_health_stream.sv | 149 ++++++++++++++
 tb/tb_trng_health_stream.sv | 130 +++++++++++++
 4 files changed

// File: rtl/trng_health_pkg.sv
// trng_health_pkg: state encoding and fail_code bit positions shared by trng_health_stream.
package trng_health_pkg;
  localparam logic [1:0] ST_STARTUP = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_ALARM   = 2'b10;
  localparam int FC_RCT = 0;
  localparam int FC_APT = 1;
  typedef enum logic [1:0] {
    STARTUP = ST_STARTUP,
    RUN     = ST_RUN,
    ALARM   = ST_ALARM
  } state_e;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/trng_health_stream_popcount.sv
// trng_popcount: combinational binary adder-tree population count of a DATA_W-bit word.
module trng_popcount #(
  parameter int DATA_W = 32,
  localparam int CW = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CW-1:0]     count_o
);
  localparam int N = 1 << $clog2(DATA_W);
  logic [N-1:0] pad;
  assign pad = N'(data_i);
  always_comb begin : tree
    logic [CW-1:0] node [1:2*N-1];
    for (int i = 0; i < N; i++) node[N+i] = CW'(pad[i]);
    for (int i = N - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
    count_o = node[1];
  end
endmodule

// File: rtl/trng_health_stream.sv
// trng_health_stream: RCT/APT online health gate between TRNG core and FIFO with sticky alarm.
// Define TRNG_HEALTH_STATS_EN to add failure totals and a forwarded-word counter.
module trng_health_stream
  import trng_health_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int RCT_CUTOFF    = 3,
  parameter int APT_WORDS     = 16,
  parameter int APT_LO        = 200,
  parameter int APT_HI        = 312,
  parameter int STARTUP_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear_alarm,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              alarm,
  output logic [1:0]        fail_code,
  output logic [1:0]        state_out
`ifdef TRNG_HEALTH_STATS_EN
  ,
  output logic [15:0]       rct_fail_total,
  output logic [15:0]       apt_fail_total,
  output logic [31:0]       words_passed
`endif
);
  localparam int PC_W  = $clog2(DATA_W + 1);
  localparam int SUM_W = $clog2(DATA_W * APT_WORDS + 1);
  localparam int WIN_W = $clog2(APT_WORDS + 1);
  localparam int ST_W  = $clog2(STARTUP_WORDS + 1);
  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              alarm_q, alarm_d;
  logic [1:0]        fail_q, fail_d;
  logic [7:0]        rct_q, rct_d, rct_new;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_new;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [PC_W-1:0]   pc;
  logic              acc, test, same, win_last, rct_fail, apt_fail, fail;
  trng_popcount #(.DATA_W(DATA_W)) u_pc (.data_i(in_data), .count_o(pc));
  assign in_ready  = enable && (state_q == ALARM || !out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign alarm     = alarm_q;
  assign fail_code = fail_q;
  assign state_out = state_q;
  // Tests only advance outside ALARM so the failing context stays frozen for inspection.
  always_comb begin
    acc          = in_valid && in_ready;
    test         = acc && state_q != ALARM;
    same         = prev_valid_q && in_data == prev_q;
    rct_new      = same ? sat_inc8(rct_q) : 8'd1;
    sum_new      = sum_q + SUM_W'(pc);
    win_last     = win_q == WIN_W'(APT_WORDS - 1);
    rct_fail     = test && rct_new >= 8'(RCT_CUTOFF);
    apt_fail     = test && win_last && (sum_new < SUM_W'(APT_LO) || sum_new > SUM_W'(APT_HI));
    fail         = rct_fail || apt_fail;
    state_d      = state_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    alarm_d      = alarm_q;
    fail_d       = fail_q;
    rct_d        = test ? rct_new : rct_q;
    prev_d       = test ? in_data : prev_q;
    prev_valid_d = test || prev_valid_q;
    sum_d        = test ? (win_last ? '0 : sum_new) : sum_q;
    win_d        = test ? (win_last ? '0 : win_q + WIN_W'(1)) : win_q;
    st_d         = st_q;
    if (fail) begin
      state_d         = ALARM;
      alarm_d         = 1'b1;
      fail_d[FC_RCT]  = fail_q[FC_RCT] | rct_fail;
      fail_d[FC_APT]  = fail_q[FC_APT] | apt_fail;
    end else if (state_q == ALARM) begin
      out_valid_d = 1'b0;
      if (clear_alarm) begin
        state_d      = STARTUP;
        alarm_d      = 1'b0;
        fail_d       = '0;
        rct_d        = '0;
        prev_valid_d = 1'b0;
        sum_d        = '0;
        win_d        = '0;
        st_d         = '0;
      end
    end else if (test && state_q == STARTUP) begin
      st_d    = (st_q == ST_W'(STARTUP_WORDS - 1)) ? '0 : st_q + ST_W'(1);
      state_d = (st_q == ST_W'(STARTUP_WORDS - 1)) ? RUN : STARTUP;
    end else if (test) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STARTUP;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      alarm_q      <= 1'b0;
      fail_q       <= '0;
      rct_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      sum_q        <= '0;
      win_q        <= '0;
      st_q         <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      alarm_q      <= alarm_d;
      fail_q       <= fail_d;
      rct_q        <= rct_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      sum_q        <= sum_d;
      win_q        <= win_d;
      st_q         <= st_d;
    end
  end
`ifdef TRNG_HEALTH_STATS_EN
  logic [15:0] rct_tot_q, apt_tot_q;
  logic [31:0] passed_q;
  assign rct_fail_total = rct_tot_q;
  assign apt_fail_total = apt_tot_q;
  assign words_passed   = passed_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rct_tot_q <= '0;
      apt_tot_q <= '0;
      passed_q  <= '0;
    end else begin
      rct_tot_q <= (rct_fail && rct_tot_q != 16'hFFFF) ? rct_tot_q + 16'd1 : rct_tot_q;
      apt_tot_q <= (apt_fail && apt_tot_q != 16'hFFFF) ? apt_tot_q + 16'd1 : apt_tot_q;
      passed_q  <= (out_valid_q && out_ready) ? passed_q + 32'd1 : passed_q;
    end
  end
`endif
endmodule

// File: tb/tb_trng_health_stream.sv
// tb_trng_health_stream: directed/random stimulus checked against a queue-based health model.
module tb_trng_health_stream;
  logic        clk = 1'b0;
  logic        rst, enable, clear_alarm, in_valid, in_ready, out_valid, out_ready, alarm;
  logic [31:0] in_data, out_data;
  logic [1:0]  fail_code, state_out;
`ifdef TRNG_HEALTH_STATS_EN
  logic [15:0] rct_tot, apt_tot;
  logic [31:0] wpass;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  trng_health_stream dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_alarm(clear_alarm),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .alarm(alarm), .fail_code(fail_code), .state_out(state_out)
`ifdef TRNG_HEALTH_STATS_EN
    , .rct_fail_total(rct_tot), .apt_fail_total(apt_tot), .words_passed(wpass)
`endif
  );
  int          m_st, m_run, m_left, m_rtot, m_atot;
  bit          m_ov, m_alarm, m_have;
  logic [31:0] m_od, m_last;
  logic [1:0]  m_fc;
  logic [31:0] m_win[$];
  int unsigned m_wp;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_restart();
    m_st = 0; m_alarm = 0; m_fc = 0; m_run = 0; m_have = 0; m_left = 32;
    m_win.delete();
  endtask
  task automatic model_reset();
    model_restart();
    m_ov = 0; m_od = 0; m_rtot = 0; m_atot = 0; m_wp = 0;
  endtask
  task automatic step(input bit en, input bit iv, input logic [31:0] d, input bit ordy,
                      input bit clr, input bit rs);
    bit rdy, acc, fr, fa;
    int s;
    enable = en; in_valid = iv; in_data = d; out_ready = ordy; clear_alarm = clr; rst = rs;
    rdy = en && (m_st == 2 || !m_ov || ordy);
    acc = iv && rdy;
    #1;
    if (!rs) chk("in_ready", in_ready, rdy);
    @(posedge clk);
    #1;
    fr = 0; fa = 0;
    if (rs) model_reset();
    else begin
      if (m_ov && ordy) begin m_ov = 0; m_wp++; end
      if (acc && m_st != 2) begin
        m_run = (m_have && d == m_last) ? m_run + 1 : 1;
        m_last = d; m_have = 1;
        fr = m_run >= 3;
        m_win.push_back(d);
        if (m_win.size() == 16) begin
          s = 0;
          foreach (m_win[i]) s += $countones(m_win[i]);
          fa = s < 200 || s > 312;
          m_win.delete();
        end
      end
      if (fr || fa) begin
        m_st = 2; m_alarm = 1; m_fc = m_fc | {fa, fr};
        if (fr && m_rtot < 65535) m_rtot++;
        if (fa && m_atot < 65535) m_atot++;
      end else if (m_st == 2) begin
        m_ov = 0;
        if (clr) model_restart();
      end else if (acc && m_st == 0) begin
        m_left--;
        if (m_left == 0) m_st = 1;
      end else if (acc) begin
        m_ov = 1; m_od = d;
      end
    end
    chk("state_out", state_out, m_st);
    chk("alarm", alarm, m_alarm);
    chk("fail_code", fail_code, m_fc);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
`ifdef TRNG_HEALTH_STATS_EN
    chk("rct_fail_total", rct_tot, m_rtot);
    chk("apt_fail_total", apt_tot, m_atot);
    chk("words_passed", wpass, m_wp);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 32; i++) step(1, 1, $urandom, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 1, i[0] ? 32'hFFFF0000 : 32'h0000FFFF, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 1, $urandom, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, $urandom, 1, 0, 0);
    step(1, 1, 32'hDEADBEEF, 1, 0, 0);
    step(1, 1, 32'hDEADBEEF, 1, 0, 0);
    step(1, 1, 32'hDEADBEEF, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 32; i++) step(1, 1, $urandom, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) for (int k = 0; k < 3; k++) step(0, 1, $urandom, 1, 0, 0);
      step(1, 1, 32'hFF << i, 1, 0, 0);
    end
    step(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 32; i++) step(1, 1, $urandom, 1, 0, 0);
    for (int i = 0; i < 13; i++) step(1, 1, 32'hFF << i, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h00FF0000, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, $urandom, 1, 0, 0);
    step(0, 1, $urandom, 1, 1, 1);
    step(1, 1, $urandom, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
